// File: rtl/spi_slave_frame_ctrl.sv
// rtl/spi_slave_frame_ctrl.sv - Mode 0 SPI slave frame sequencer in the system clock domain
module spi_slave_frame_ctrl #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] DUMMY_BYTE  = 8'hFF
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_scl,
    input  logic       i_cs,
    input  logic       i_mosi,
    output logic       o_miso,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_we,
    output logic       o_tx_ready,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    input  logic       i_rx_ack,
    output logic       o_ovr,
    output logic       o_frm_err,
    input  logic       i_err_clr,
    output logic       o_busy,
    output logic       o_irq
);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   scl_d;
    logic                   cs_d;
    logic                   scl_s;
    logic                   cs_s;
    logic                   mosi_s;
    logic                   scl_rise;
    logic                   scl_fall;
    logic                   cs_fall;

    // o_miso carries bit 7; tx_rest holds the bits still to follow it
    logic [6:0]             tx_rest;
    logic [6:0]             rx_shift;
    logic [7:0]             tx_buf;
    logic [2:0]             bit_cnt;
    logic                   reload_pend;
    logic [7:0]             load_byte;
    logic [7:0]             rx_byte;
    logic                   load_now;
    logic                   rx_done;
    logic                   frm_abort;

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign load_byte = o_tx_ready ? DUMMY_BYTE : tx_buf;
    assign rx_byte   = {rx_shift, mosi_s};
    assign load_now  = (state == ST_LOAD) ||
                       ((state == ST_SHIFT) && !cs_s && scl_fall && reload_pend);
    assign rx_done   = (state == ST_SHIFT) && !cs_s && scl_rise && (bit_cnt == 3'd7);
    assign frm_abort = (state == ST_SHIFT) && cs_s && (bit_cnt != 3'd0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            scl_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            scl_d     <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            scl_sync  <= {scl_sync[SYNC_STAGES-2:0], i_scl};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_mosi};
            scl_d     <= scl_s;
            cs_d      <= cs_s;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            o_miso      <= 1'b0;
            tx_rest     <= '0;
            rx_shift    <= '0;
            bit_cnt     <= '0;
            reload_pend <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    o_miso <= 1'b0;
                    if (cs_fall) state <= ST_LOAD;
                end
                ST_LOAD: begin
                    o_miso      <= load_byte[7];
                    tx_rest     <= load_byte[6:0];
                    bit_cnt     <= '0;
                    reload_pend <= 1'b0;
                    state       <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    // level check rather than edge so a CS pulse that ends during LOAD still exits
                    if (cs_s) begin
                        state       <= ST_IDLE;
                        o_miso      <= 1'b0;
                        bit_cnt     <= '0;
                        reload_pend <= 1'b0;
                    end else begin
                        if (scl_rise) begin
                            rx_shift <= rx_byte[6:0];
                            bit_cnt  <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) reload_pend <= 1'b1;
                        end
                        if (scl_fall) begin
                            if (reload_pend) begin
                                o_miso      <= load_byte[7];
                                tx_rest     <= load_byte[6:0];
                                reload_pend <= 1'b0;
                            end else begin
                                o_miso  <= tx_rest[6];
                                tx_rest <= {tx_rest[5:0], 1'b0};
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // a load from an empty buffer leaves it empty, so a coincident write still lands
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tx_buf     <= '0;
            o_tx_ready <= 1'b1;
        end else if (load_now && !o_tx_ready) begin
            o_tx_ready <= 1'b1;
        end else if (i_tx_we && o_tx_ready) begin
            tx_buf     <= i_tx_data;
            o_tx_ready <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_rx_data  <= '0;
            o_rx_valid <= 1'b0;
            o_ovr      <= 1'b0;
            o_frm_err  <= 1'b0;
            o_busy     <= 1'b0;
            o_irq      <= 1'b0;
        end else begin
            if (rx_done && (!o_rx_valid || i_rx_ack)) begin
                o_rx_data  <= rx_byte;
                o_rx_valid <= 1'b1;
            end else if (i_rx_ack) begin
                o_rx_valid <= 1'b0;
            end
            o_ovr     <= (rx_done && o_rx_valid && !i_rx_ack) || (o_ovr && !i_err_clr);
            o_frm_err <= frm_abort || (o_frm_err && !i_err_clr);
            o_busy    <= ~cs_s;
            o_irq     <= o_rx_valid | o_ovr | o_frm_err;
        end
    end

endmodule

// File: doc/spi_slave_frame_ctrl.md
Name: spi_slave_frame_ctrl

Overview:
- Controls a Mode 0 SPI slave (CPOL=0, CPHA=0) entirely in the i_clk domain.
- Oversamples SCLK/CS/MOSI through synchronizers and sequences each frame: bit counting, byte framing, TX preload and RX hand-off to the 8051 core.
- Manages overrun/abort error flags and a level interrupt.
- Sits between the external STM32 master pins and the core's SFR/interrupt logic.

Parameters:
- SYNC_STAGES, 2: flops per input synchronizer (must be ≥2).
- DUMMY_BYTE, 8'hFF: byte shifted out when no TX byte is loaded.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  reset, asynchronous, active-high
- i_scl  in  1  SPI clock from master (asynchronous)
- i_cs  in  1  chip select, active-low (asynchronous)
- i_mosi  in  1  master-out data (asynchronous)
- o_miso  out  1  slave-out data
- i_tx_data  in  8  byte to transmit
- i_tx_we  in  1  write strobe for i_tx_data
- o_tx_ready  out  1  TX buffer empty, write accepted
- o_rx_data  out  8  last received byte
- o_rx_valid  out  1  o_rx_data holds an unread byte
- i_rx_ack  in  1  core has read o_rx_data
- o_ovr  out  1  sticky: byte completed while o_rx_valid=1 and not acked
- o_frm_err  out  1  sticky: CS deasserted mid-byte
- i_err_clr  in  1  clears o_ovr and o_frm_err
- o_busy  out  1  frame in progress (synced CS low)
- o_irq  out  1  level interrupt

Behaviour:
- Reset values: o_miso=0, o_rx_data=0, o_rx_valid=0, o_tx_ready=1, o_ovr=0, o_frm_err=0, o_busy=0, o_irq=0.
- Reset state: FSM IDLE, bit counter 0, TX buffer empty.
- Reset mid-frame aborts the frame silently; o_frm_err is not set.
- Synchronization:
  - SCLK, CS and MOSI each pass through SYNC_STAGES flops.
  - Edges are detected by comparing the last sync stage with one extra flop.
  - SCLK frequency must be ≤ i_clk/8.
- FSM states:
  - IDLE: synced CS high; o_miso=0. On CS falling edge → LOAD.
  - LOAD (1 cycle):
    - tx_shift ← TX buffer if full, else DUMMY_BYTE.
    - If the buffer was full, it is emptied (o_tx_ready=1 next cycle).
    - bit counter ← 0; → SHIFT.
  - SHIFT:
    - o_miso = tx_shift[7].
    - SCLK rising: rx_shift ← {rx_shift[6:0], mosi_sync}; bit counter +1.
    - SCLK falling: tx_shift ← {tx_shift[6:0], 0}.
    - 8th rising edge (counter wraps 7→0): byte complete → RX hand-off.
    - Falling edge after a completed byte: reload tx_shift exactly as in LOAD (buffer or DUMMY_BYTE), instead of shifting.
    - CS rising edge: → IDLE. If counter≠0, the partial byte is discarded and o_frm_err is set.
- RX hand-off on byte complete (registered, visible the cycle after detection):
  - If o_rx_valid=0, or i_rx_ack=1 in the same cycle: o_rx_data ← byte, o_rx_valid=1.
  - Else: byte dropped, o_rx_data unchanged, o_ovr set.
  - i_rx_ack alone clears o_rx_valid next cycle.
- TX buffer:
  - i_tx_we with o_tx_ready=1 stores the byte; o_tx_ready=0 next cycle.
  - i_tx_we with o_tx_ready=0 is ignored (no overwrite).
  - i_tx_we in the same cycle as a load from an empty buffer: DUMMY_BYTE is shifted and the write lands in the buffer.
- Error flags:
  - i_err_clr clears both error flags.
  - A set event in the same cycle as i_err_clr wins (flag stays 1).
- o_busy = synced CS inverted, registered.
- o_irq = o_rx_valid | o_ovr | o_frm_err, registered (1-cycle latency).
- Full-duplex byte latency: o_rx_valid rises ≤ SYNC_STAGES+2 i_clk cycles after the 8th SCLK rising edge at the pins.

Test Plan:
- Preload 8'hA5, master sends 8'h3C in one 8-clock frame → MISO bits 1,0,1,0,0,1,0,1; o_rx_data=8'h3C; o_rx_valid=1; o_tx_ready=1 after LOAD; o_irq=1.
- No preload, master sends 8'h00 → MISO shifts 8'hFF (DUMMY_BYTE); o_rx_data=8'h00.
- Two-byte frame 8'h11, 8'h22 with no i_rx_ack → o_rx_data stays 8'h11, o_ovr=1; i_err_clr → o_ovr=0.
- Two-byte frame with i_rx_ack asserted in the same cycle the second byte completes → o_rx_data=8'h22, o_rx_valid=1, o_ovr=0.
- CS deasserted after 5 SCLKs → o_frm_err=1, o_rx_valid unchanged; the next full frame with 8'h5A receives correctly.
- Assert i_rst mid-byte (bit 3) → all outputs at reset values within 1 cycle; a subsequent frame with 8'hC3 is received intact.
